mmio_responder: RTL and testbench

Memory-mapped peripheral responder on the CPU memory bus, the slave end of the Address/Wr/Datain/Dataout interface that the multicycle CPU drives. It decodes a 16-byte window at `BASE_ADDR`, answers reads with a registered one-cycle latency matching the main memory, and accepts single-cycle writes. It holds an LED register, a free-running cycle counter and a transmit FIFO, which is drained on a valid/ready stream port. The top level muxes `Dataout` between main memory and this block using `hit_q`.

---
 rtl/mmio_responder.sv | 119 +++++++++++
 tb/tb_mmio_responder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mmio_responder.sv
// Memory-mapped responder: LED register, optional cycle counter and a TX FIFO
// drained over a valid/ready port. Counter is built only with `MMIO_CYCLE_COUNTER_EN.
module mmio_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic        Wr,
  input  logic [31:0] Datain,
  output logic [31:0] Dataout,
  output logic        hit_q,
  output logic [15:0] leds,
  output logic        tx_valid,
  output logic [31:0] tx_data,
  input  logic        tx_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic          hit;
  logic [1:0]    idx;
  logic          wr_led, wr_tx, wr_stat;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          overflow, empty, full, pop, push_ok;
  logic [7:0]    cnt_ext;
  logic [31:0]   cycles_rd, rd_val;

  assign hit     = (Address[31:4] == BASE_ADDR[31:4]);
  assign idx     = Address[3:2];
  assign wr_led  = Wr && hit && (idx == 2'd0);
  assign wr_tx   = Wr && hit && (idx == 2'd2);
  assign wr_stat = Wr && hit && (idx == 2'd3);

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign tx_valid = !empty;
  assign tx_data  = empty ? 32'h0 : mem[rd_ptr];
  assign pop      = tx_valid && tx_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok  = wr_tx && (!full || pop);
  assign cnt_ext  = 8'(count);

`ifdef MMIO_CYCLE_COUNTER_EN
  logic        wr_cyc;
  logic        phase;
  logic [31:0] cycles;

  assign wr_cyc    = Wr && hit && (idx == 2'd1);
  assign cycles_rd = cycles;

  always_ff @(posedge clk) begin
    if (reset) begin
      phase  <= 1'b0;
      cycles <= 32'h0;
    end else begin
      phase <= ~phase;
      if (wr_cyc)     cycles <= 32'h0;
      else if (phase) cycles <= cycles + 32'd1;
    end
  end
`else
  assign cycles_rd = 32'h0;
`endif

  always_ff @(posedge clk) begin
    if (!reset && push_ok) mem[wr_ptr] <= Datain;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      leds     <= 16'h0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_led)  wr_ptr <= wr_ptr;
      if (wr_led)  leds   <= Datain[15:0];
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_tx && full && !pop)       overflow <= 1'b1;
      else if (wr_stat && Datain[1])   overflow <= 1'b0;
    end
  end

  always_comb begin
    rd_val = 32'h0;
    case (idx)
      2'd0: rd_val = {16'h0, leds};
      2'd1: rd_val = cycles_rd;
      2'd2: rd_val = tx_data;
      2'd3: rd_val = {26'h0, cnt_ext[3:0], overflow, empty};
      default: rd_val = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      Dataout <= 32'h0;
      hit_q   <= 1'b0;
    end else begin
      Dataout <= hit ? rd_val : 32'h0;
      hit_q   <= hit;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{Address[1:0], cnt_ext[7:4]};

endmodule

// File: tb/tb_mmio_responder.sv
// Directed bench for mmio_responder: registers, FIFO overflow/drain, same-cycle
// push/pop, cycle counter (or its absence) and mid-transfer reset.
module tb_mmio_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Address;
  logic        Wr;
  logic [31:0] Datain;
  logic [31:0] Dataout;
  logic        hit_q;
  logic [15:0] leds;
  logic        tx_valid;
  logic [31:0] tx_data;
  logic        tx_ready;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [31:0] A_LED  = 32'hFFFF_0000;
  localparam logic [31:0] A_CYC  = 32'hFFFF_0004;
  localparam logic [31:0] A_TX   = 32'hFFFF_0008;
  localparam logic [31:0] A_STAT = 32'hFFFF_000C;

  mmio_responder dut (
    .clk(clk), .reset(reset), .Address(Address), .Wr(Wr), .Datain(Datain),
    .Dataout(Dataout), .hit_q(hit_q), .leds(leds), .tx_valid(tx_valid),
    .tx_data(tx_data), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    Address = a; Datain = d; Wr = 1'b1;
    cyc();
    Wr = 1'b0; Address = 32'h0; Datain = 32'h0;
  endtask

  task automatic rd(input logic [31:0] a);
    Address = a; Wr = 1'b0;
    cyc();
    Address = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1; Wr = 1'b0; Address = 32'h0; Datain = 32'h0; tx_ready = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
    n_cmp++; if (leds !== 16'h0) begin n_bad++; $display("FAIL rst_leds got %h exp 0", leds); end
    n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL rst_tx_valid got %b exp 0", tx_valid); end
    n_cmp++; if (tx_data !== 32'h0) begin n_bad++; $display("FAIL rst_tx_data got %h exp 0", tx_data); end
    n_cmp++; if (hit_q !== 1'b0 || Dataout !== 32'h0) begin n_bad++; $display("FAIL rst_rd got hit %b data %h exp 0/0", hit_q, Dataout); end
    rd(A_LED);
    n_cmp++; if (hit_q !== 1'b1 || Dataout !== 32'h0) begin n_bad++; $display("FAIL rst_led got hit %b data %h exp 1/0", hit_q, Dataout); end
    rd(A_CYC);
`ifdef MMIO_CYCLE_COUNTER_EN
    n_cmp++; if (hit_q !== 1'b1 || Dataout > 32'd1) begin n_bad++; $display("FAIL rst_cyc got hit %b data %h exp 1/<=1", hit_q, Dataout); end
`else
    n_cmp++; if (hit_q !== 1'b1 || Dataout !== 32'h0) begin n_bad++; $display("FAIL rst_cyc got hit %b data %h exp 1/0", hit_q, Dataout); end
`endif
    rd(A_STAT);
    n_cmp++; if (hit_q !== 1'b1 || Dataout !== 32'h1) begin n_bad++; $display("FAIL rst_stat got hit %b data %h exp 1/1", hit_q, Dataout); end
  endtask

  task automatic test_leds();
    wr(A_LED, 32'h1234_ABCD);
    n_cmp++; if (leds !== 16'hABCD) begin n_bad++; $display("FAIL led_wr got %h exp abcd", leds); end
    rd(A_LED);
    n_cmp++; if (Dataout !== 32'h0000_ABCD) begin n_bad++; $display("FAIL led_rd got %h exp 0000abcd", Dataout); end
    rd(32'hFFFF_0003);
    n_cmp++; if (Dataout !== 32'h0000_ABCD) begin n_bad++; $display("FAIL led_rd_byte got %h exp 0000abcd", Dataout); end
    rd(32'h0000_0010);
    n_cmp++; if (hit_q !== 1'b0 || Dataout !== 32'h0) begin n_bad++; $display("FAIL miss_rd got hit %b data %h exp 0/0", hit_q, Dataout); end
    wr(32'hFFFF_0010, 32'h0000_5555);
    n_cmp++; if (leds !== 16'hABCD) begin n_bad++; $display("FAIL miss_wr got %h exp abcd", leds); end
    wr(32'h7FFF_0000, 32'h0000_6666);
    n_cmp++; if (leds !== 16'hABCD || hit_q !== 1'b0) begin n_bad++; $display("FAIL miss_wr2 got %h/%b exp abcd/0", leds, hit_q); end
  endtask

  task automatic test_fifo_overflow();
    tx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) wr(A_TX, 32'(i));
    n_cmp++; if (tx_valid !== 1'b1 || tx_data !== 32'd1) begin n_bad++; $display("FAIL ovf_head got %b/%h exp 1/1", tx_valid, tx_data); end
    rd(A_TX);
    n_cmp++; if (Dataout !== 32'd1) begin n_bad++; $display("FAIL txdata_rd got %h exp 1", Dataout); end
    rd(A_STAT);
    n_cmp++; if (Dataout !== 32'h12) begin n_bad++; $display("FAIL ovf_stat got %h exp 12", Dataout); end
    tx_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      n_cmp++; if (tx_valid !== 1'b1 || tx_data !== 32'(i)) begin n_bad++; $display("FAIL drain_%0d got %b/%h exp 1/%h", i, tx_valid, tx_data, 32'(i)); end
      cyc();
    end
    n_cmp++; if (tx_valid !== 1'b0 || tx_data !== 32'h0) begin n_bad++; $display("FAIL drain_empty got %b/%h exp 0/0", tx_valid, tx_data); end
    tx_ready = 1'b0;
    rd(A_STAT);
    n_cmp++; if (Dataout !== 32'h3) begin n_bad++; $display("FAIL ovf_sticky got %h exp 3", Dataout); end
    wr(A_STAT, 32'h1);
    rd(A_STAT);
    n_cmp++; if (Dataout !== 32'h3) begin n_bad++; $display("FAIL ovf_noclr got %h exp 3", Dataout); end
    wr(A_STAT, 32'h2);
    rd(A_STAT);
    n_cmp++; if (Dataout !== 32'h1) begin n_bad++; $display("FAIL ovf_clr got %h exp 1", Dataout); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q [4];
    exp_q = '{32'h11, 32'h12, 32'h13, 32'hDEAD};
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) wr(A_TX, 32'h10 + 32'(i));
    tx_ready = 1'b1;
    wr(A_TX, 32'hDEAD);
    tx_ready = 1'b0;
    rd(A_STAT);
    n_cmp++; if (Dataout !== 32'h10) begin n_bad++; $display("FAIL full_pp_stat got %h exp 10", Dataout); end
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (tx_valid !== 1'b1 || tx_data !== exp_q[i]) begin n_bad++; $display("FAIL full_pp_drain_%0d got %b/%h exp 1/%h", i, tx_valid, tx_data, exp_q[i]); end
      cyc();
    end
    n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL full_pp_empty got %b exp 0", tx_valid); end
    wr(A_TX, 32'h55);
    n_cmp++; if (tx_valid !== 1'b1 || tx_data !== 32'h55) begin n_bad++; $display("FAIL empty_pp got %b/%h exp 1/55", tx_valid, tx_data); end
    cyc();
    n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL empty_pp_pop got %b exp 0", tx_valid); end
    tx_ready = 1'b0;
  endtask

  task automatic test_cycles();
`ifdef MMIO_CYCLE_COUNTER_EN
    wr(A_CYC, 32'hFFFF_FFFF);
    for (int i = 0; i < 20; i++) cyc();
    rd(A_CYC);
    n_cmp++; if (Dataout < 32'd9 || Dataout > 32'd11) begin n_bad++; $display("FAIL cyc_idle got %0d exp 10+-1", Dataout); end
    wr(A_CYC, 32'h1234);
    rd(A_CYC);
    n_cmp++; if (Dataout > 32'd1) begin n_bad++; $display("FAIL cyc_clr got %0d exp 0..1", Dataout); end
`else
    wr(A_CYC, 32'hFFFF_FFFF);
    for (int i = 0; i < 20; i++) cyc();
    rd(A_CYC);
    n_cmp++; if (hit_q !== 1'b1 || Dataout !== 32'h0) begin n_bad++; $display("FAIL cyc_absent got %b/%h exp 1/0", hit_q, Dataout); end
    n_cmp++; if (leds !== 16'hABCD) begin n_bad++; $display("FAIL cyc_wr_side got %h exp abcd", leds); end
`endif
  endtask

  task automatic test_reset_mid();
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) wr(A_TX, 32'hA0 + 32'(i));
    tx_ready = 1'b1;
    reset = 1'b1;
    wr(A_TX, 32'hBEEF);
    reset = 1'b0;
    n_cmp++; if (tx_valid !== 1'b0 || tx_data !== 32'h0) begin n_bad++; $display("FAIL mid_rst_fifo got %b/%h exp 0/0", tx_valid, tx_data); end
    n_cmp++; if (leds !== 16'h0) begin n_bad++; $display("FAIL mid_rst_leds got %h exp 0", leds); end
    rd(A_STAT);
    n_cmp++; if (Dataout !== 32'h1) begin n_bad++; $display("FAIL mid_rst_stat got %h exp 1", Dataout); end
    tx_ready = 1'b0;
    wr(A_TX, 32'h77);
    n_cmp++; if (tx_valid !== 1'b1 || tx_data !== 32'h77) begin n_bad++; $display("FAIL mid_rst_repush got %b/%h exp 1/77", tx_valid, tx_data); end
  endtask

  initial begin
    test_reset();
    test_leds();
    test_fifo_overflow();
    test_back_to_back();
    test_cycles();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
